uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: ticks per bit, even, legal 8..32.
REQ-003 SHALL have parameter CLKS_PER_TICK, default 1: clk cycles per oversample tick, legal 1..65535.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous reset, active-low.
REQ-008 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-009 SHALL have port enable  in  1  receive enable.
REQ-010 SHALL have port data  out  DATA_W  received word, LSB first on the line.
REQ-011 SHALL have port valid  out  1  data and flags valid; held until ack.
REQ-012 SHALL have port ack  in  1  consumer accepts data when valid & ack.
REQ-013 SHALL have port frame_err  out  1  stop-bit error for the held word.
REQ-014 SHALL have port parity_err  out  1  parity error for the held word; tied 0 without macro.
REQ-015 SHALL have port overrun  out  1  sticky; a frame was dropped while valid was high.
REQ-016 SHALL have port busy  out  1  FSM not IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only with macro.
REQ-019 SHALL, in IDLE with enable=1, enter START on a synchronized 1->0 transition and restart the tick counter.
REQ-020 SHALL, in START after OVERSAMPLE/2 ticks, sample rx: 0 -> DATA; 1 -> IDLE, glitch rejected, no flags.
REQ-021 SHALL sample each data bit every OVERSAMPLE ticks after mid-start, shifting LSB first, DATA_W samples, then PARITY or STOP.
REQ-022 SHALL sample STOP_BITS stop bits at mid-bit; any 0 sets the frame error of that frame.
REQ-023 SHALL, one clk after the final stop sample, return to IDLE and, if valid=0 or ack=1, load data, frame_err, parity_err and set valid.
REQ-024 SHALL, if valid=1 and ack=0 at completion, drop the new frame, keep the held word and flags, and set overrun.
REQ-025 SHALL clear valid on valid & ack unless a new word loads in the same cycle, in which case valid stays 1.
REQ-026 SHALL clear overrun only on valid & ack.
REQ-027 SHALL, when enable=0, force FSM to IDLE on the next clk, discarding any partial frame; valid, data and flags unaffected.
REQ-028 SHALL still deliver errored frames; frame_err and parity_err are meaningful only while valid=1.

Reset
REQ-029 SHALL, on rst_n=0, immediately set FSM=IDLE, counters=0, synchronizer flops=1, data=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-030 SHALL discard a frame in progress when reset asserts mid-frame; after release, reception resumes on the next falling edge.

Configuration
REQ-031 SHALL, with UART_RX_PARITY_EN defined, receive one parity bit after the data bits and set parity_err on mismatch against PARITY_ODD.
REQ-032 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and hold parity_err at 0.

Structure
REQ-033 SHALL place the FSM state enum and the parameter legal-range limits in shared package uart_pkg.
REQ-034 SHALL instantiate sub-module uart_baud_tick, which divides clk by CLKS_PER_TICK into a one-cycle tick and restarts on a sync input.

Verification
REQ-035 SHALL verify: defaults, CLKS_PER_TICK=1, frame 0xA5 at 16 clk/bit -> data=0xA5, valid=1, frame_err=0, 1 clk after stop mid-sample.
REQ-036 SHALL verify: 4-clk low glitch on idle rx -> busy returns 0 after the start mid-sample, valid stays 0.
REQ-037 SHALL verify: 0x3C sent with stop bit 0 -> data=0x3C, valid=1, frame_err=1.
REQ-038 SHALL verify: 0x11 then 0x22 sent with ack=0 -> data=0x11, overrun=1; after ack, valid=0 and overrun=0.
REQ-039 SHALL verify: rst_n pulsed low during data bit 3, then 0x5A sent -> only 0x5A delivered, no error flags.
REQ-040 SHALL verify: with macro and PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err=1, data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM state encoding,
// legal parameter ranges and a counter-width helper.
package uart_pkg;

    localparam int DATA_W_MIN        = 5;
    localparam int DATA_W_MAX        = 9;
    localparam int OVERSAMPLE_MIN    = 8;
    localparam int OVERSAMPLE_MAX    = 32;
    localparam int CLKS_PER_TICK_MIN = 1;
    localparam int CLKS_PER_TICK_MAX = 65535;
    localparam int STOP_BITS_MIN     = 1;
    localparam int STOP_BITS_MAX     = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    // Width able to hold the values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Divides clk by CLKS_PER_TICK into a one-cycle oversample tick; sync restarts
// the division so the first tick lands a full period after the restart.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (sync || (cnt_reg == LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST) && !sync;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a valid/ack holding register and sticky overrun.
// Optional parity reception is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 1,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              enable,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ack,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_W);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    generate
        if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
            $error("uart_rx_param: DATA_W out of range");
        end
        if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx_param: OVERSAMPLE out of range or odd");
        end
        if (CLKS_PER_TICK < CLKS_PER_TICK_MIN || CLKS_PER_TICK > CLKS_PER_TICK_MAX) begin : g_bad_cpt
            $error("uart_rx_param: CLKS_PER_TICK out of range");
        end
        if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
            $error("uart_rx_param: STOP_BITS out of range");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
            $error("uart_rx_param: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    logic [2:0] rx_pipe_reg;
    logic       rx_sync;
    logic       rx_prev;
    logic       start_det;
    logic       tick;
    logic       bit_point;

    uart_state_e        state_reg, state_next;
    logic [TW-1:0]      tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic               ferr_acc_reg, ferr_acc_next;
    logic               done_reg, done_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               frame_err_reg, frame_err_next;
    logic               overrun_reg, overrun_next;
`ifdef UART_RX_PARITY_EN
    logic               perr_acc_reg, perr_acc_next;
    logic               parity_err_reg, parity_err_next;
`endif

    assign rx_sync   = rx_pipe_reg[1];
    assign rx_prev   = rx_pipe_reg[2];
    assign start_det = enable && (state_reg == ST_IDLE) && rx_prev && !rx_sync;
    assign bit_point = tick && (tick_cnt_reg == FULL_LAST);

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .sync (start_det),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pipe_reg   <= '1;
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ferr_acc_reg  <= 1'b0;
            done_reg      <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            rx_pipe_reg   <= {rx_pipe_reg[1:0], rx};
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ferr_acc_reg  <= ferr_acc_next;
            done_reg      <= done_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
`ifdef UART_RX_PARITY_EN
            perr_acc_reg   <= perr_acc_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Receive FSM: tick counting and bit sampling.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        ferr_acc_next = ferr_acc_reg;
        done_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_acc_next = perr_acc_reg;
`endif
        if (tick && state_reg != ST_IDLE) begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_det) begin
                    state_next    = ST_START;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    ferr_acc_next = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_acc_next = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick && tick_cnt_reg == HALF_LAST) begin
                    tick_cnt_next = '0;
                    state_next    = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_point) begin
                    tick_cnt_next = '0;
                    shift_next    = {rx_sync, shift_reg[DATA_W-1:1]};
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        state_next   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_point) begin
                    tick_cnt_next = '0;
                    perr_acc_next = ((^shift_reg) ^ rx_sync) != PARITY_ODD[0];
                    state_next    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (done_reg) begin
                    state_next    = ST_IDLE;
                    tick_cnt_next = '0;
                end else if (bit_point) begin
                    tick_cnt_next = '0;
                    if (!rx_sync) begin
                        ferr_acc_next = 1'b1;
                    end
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_next = ST_IDLE;
            done_next  = 1'b0;
        end
    end

    // Holding register: a completed frame loads only if the slot is free or freeing now.
    always_comb begin
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = frame_err_reg;
        overrun_next   = overrun_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err_reg;
`endif
        if (valid_reg && ack) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end
        if (done_reg) begin
            if (!valid_reg || ack) begin
                data_next      = shift_reg;
                frame_err_next = ferr_acc_reg;
                valid_next     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_next = perr_acc_reg;
`endif
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule
